parity_frame_accum: RTL and testbench
=====================================

# parity_frame_accum

Streaming, parametrised parity engine with frame support. It reduces each WIDTH-bit input beat to a configurable-polarity parity bit (XOR or XNOR), and reports that beat parity one cycle after the beat is accepted. It also accumulates parity across a frame delimited by `in_last` and presents one registered result per frame on a valid/ready output with a beat count. It sits between a beat-oriented data source and a checker/scoreboard consumer.

## Interface
Parameters:
- `WIDTH`, default 3: bits per input beat, ≥1.
- `INVERT`, default 1: 1 = XNOR polarity (result = ~^data); 0 = XOR polarity (result = ^data).
- `CNT_W`, default 8: width of the beat counter and error counter, ≥2.

Ports:
- `clk`, input, 1: clock; all state on posedge.
- `areset`, input, 1: reset is asynchronous and active-high.
- `in_data`, input, WIDTH: beat payload.
- `in_valid`, input, 1: beat present.
- `in_last`, input, 1: beat is the final beat of its frame; qualified by `in_valid`.
- `in_ready`, output, 1: beat accepted when `in_valid && in_ready`.
- `beat_par`, output, 1: registered parity of the last accepted beat.
- `beat_valid`, output, 1: one-cycle pulse accompanying `beat_par`.
- `res_parity`, output, 1: frame parity.
- `res_beats`, output, CNT_W: beats in the frame, saturating.
- `res_valid`, output, 1: frame result held.
- `res_ready`, input, 1: consumer accepts the result.

## Operation
- Accept condition: `acc_en = in_valid && in_ready`.
- `in_ready = !res_valid || res_ready` (combinational from `res_ready`). The block stalls all beats, not only last beats, while a result is unaccepted.
- Beat parity: `bp = (^in_data) ^ INVERT`.
- On accept: `beat_par <= bp` and `beat_valid <= 1`. Otherwise `beat_valid <= 0` and `beat_par` holds.
- FSM states:
  - IDLE: no beats accumulated.
  - ACC: frame in progress.
- FSM transitions:
  - IDLE, accept, !last → ACC.
  - IDLE, accept, last → IDLE; single-beat frame.
  - ACC, accept, last → IDLE.
  - ACC, accept, !last → ACC.
- Accumulator `acc` (raw XOR, no polarity):
  - Accept in IDLE: `acc <= ^in_data`.
  - Accept in ACC: `acc <= acc ^ (^in_data)`.
- Counter `cnt`:
  - Accept in IDLE: `cnt <= 1`.
  - Accept in ACC: `cnt <= cnt+1`, saturating at 2^CNT_W−1.
- Accepting a last beat:
  - `res_parity <= (acc_next) ^ INVERT`.
  - `res_beats <= cnt_next`.
  - `res_valid <= 1`.
  - `acc_next` and `cnt_next` include the current beat.
- Result handshake: `res_valid && res_ready` with no last beat accepted that cycle → `res_valid <= 0`. Data outputs hold their values.
- Simultaneous result handshake and last-beat accept: `res_valid` stays 1 and the new result is loaded. This is legal because `in_ready` is high when `res_ready` is high.
- `res_parity` and `res_beats` are stable while `res_valid && !res_ready`.

## Timing
- Reset values (asynchronous):
  - FSM = IDLE.
  - `acc`, `cnt` = 0.
  - `beat_par`, `beat_valid` = 0.
  - `res_parity`, `res_beats`, `res_valid` = 0.
  - `in_ready` = 1 (follows from `res_valid` = 0).
  - `err_cnt`, `res_err` = 0.
- Latency:
  - `beat_par`/`beat_valid`: 1 cycle after accept.
  - `res_valid`: 1 cycle after the last beat is accepted.
- Throughput: one beat per cycle while the consumer keeps `res_ready` high. Back-to-back single-beat frames produce a result every cycle.
- Reset mid-frame: the partial frame is discarded and the next accepted beat starts a new frame. A pending result is dropped.
- `in_last` without `in_valid` is ignored.

## Configuration
- Macro `PARITY_ERR_EN`.
- When defined, the following ports are added:
  - Input `in_exp` (1 bit): expected frame parity, sampled with the last beat.
  - Output `res_err` (1 bit): loaded together with `res_parity` as `res_parity_next != in_exp`.
  - Output `err_cnt` (CNT_W bits): increments on each such mismatching frame, saturating. It is reset only by `areset`.
- When undefined: these ports and all associated logic are absent, and the behaviour is otherwise identical.

## Test plan
All scenarios use WIDTH=3 and INVERT=1 unless noted.
- **Single-beat frame:** after reset, send `3'b000` with last and `res_ready=1`. Next cycle: `beat_par=1`, `beat_valid=1`, `res_valid=1`, `res_parity=1`, `res_beats=1`. One cycle later: `res_valid=0`.
- **Multi-beat frame:** send `3'b001`, then `3'b000` with last. Required: `beat_par` = 0 then 1, `res_parity=0`, `res_beats=2`. With INVERT=0 the same stimulus gives `res_parity=1`.
- **Backpressure:** with `res_ready=0` and one result pending, present the next frame's beats. Required: `in_ready=0`, no `beat_valid`, and the pending result is held unchanged. Then raise `res_ready` in the same cycle as a last beat of `3'b111`. Required: the old result is consumed, `res_valid` stays 1, new `res_parity=0`, `res_beats=1`.
- **Saturation:** with CNT_W=4, send a 20-beat frame of `3'b000`. Required: `res_beats=15`, `res_parity=1`.
- **Asynchronous reset mid-frame:** send two beats of `3'b001`, pulse `areset` between clock edges, then send `3'b111` with last. Required: all outputs reach their reset values immediately; afterwards `res_parity=0` and `res_beats=1`.
- **`PARITY_ERR_EN` defined:** send frame `3'b000`+last with `in_exp=0`, then `3'b001`+last with `in_exp=0`. Required: first result `res_err=1`, `err_cnt=1`; second result `res_parity=0`, `res_err=0`, `err_cnt` remains 1.

Source files
------------

// File: rtl/parity_frame_accum.sv
// ---------------------------------------------------------------------------
// parity_frame_accum
//
// Streaming parity engine with frame support. Each accepted WIDTH-bit beat is
// reduced to one parity bit (XOR, or XNOR when INVERT=1) and reported one
// cycle later on beat_par/beat_valid. Beats are also accumulated across a
// frame delimited by in_last; one registered result per frame (parity plus a
// saturating beat count) is presented on a valid/ready output.
//
// Optional feature: define PARITY_ERR_EN to add an expected-parity input
// (in_exp), a per-frame mismatch flag (res_err) and a saturating mismatch
// counter (err_cnt). With the macro undefined those ports and their logic are
// absent.
//
// Parameters:
//   WIDTH  - bits per input beat (>=1)
//   INVERT - 1 = XNOR polarity, 0 = XOR polarity
//   CNT_W  - width of beat and error counters (>=2)
//
// Ports:
//   clk         in   clock, all state on posedge
//   areset      in   asynchronous active-high reset
//   in_data     in   beat payload [WIDTH]
//   in_valid    in   beat present
//   in_last     in   final beat of frame (qualified by in_valid)
//   in_ready    out  beat accepted when in_valid && in_ready
//   beat_par    out  registered parity of last accepted beat
//   beat_valid  out  one-cycle pulse with beat_par
//   res_parity  out  frame parity
//   res_beats   out  beats in frame, saturating [CNT_W]
//   res_valid   out  frame result held
//   res_ready   in   consumer accepts result
//   dbg_state   out  frame FSM state (0 = IDLE, 1 = ACC)
//   in_exp      in   (PARITY_ERR_EN) expected frame parity, sampled with last
//   res_err     out  (PARITY_ERR_EN) frame parity differed from in_exp
//   err_cnt     out  (PARITY_ERR_EN) mismatching frames, saturating [CNT_W]
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its payload stable until the
// transfer; ready may depend combinationally on the consumer side. Here
// in_ready = !res_valid || res_ready, so while a frame result is waiting to be
// taken every input beat stalls, and a result handshake frees the input in
// the same cycle.
// ---------------------------------------------------------------------------
module parity_frame_accum #(
    parameter int WIDTH  = 3,
    parameter int INVERT = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             beat_par,
    output logic             beat_valid,
    output logic             res_parity,
    output logic [CNT_W-1:0] res_beats,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef PARITY_ERR_EN
    input  logic             in_exp,
    output logic             res_err,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic             INV     = (INVERT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               beat_par_q, beat_par_d;
    logic               beat_valid_q, beat_valid_d;
    logic               res_parity_q, res_parity_d;
    logic [CNT_W-1:0]   res_beats_q, res_beats_d;
    logic               res_valid_q, res_valid_d;

    logic               acc_en;
    logic               last_en;
    logic               beat_x;
    logic               acc_next;
    logic [CNT_W-1:0]   cnt_next;

    assign in_ready = !res_valid_q || res_ready;
    assign acc_en   = in_valid && in_ready;
    assign last_en  = acc_en && in_last;
    assign beat_x   = ^in_data;

    // Values including the current beat; a beat seen in IDLE opens a new
    // frame, so it overwrites rather than extends the running totals.
    always_comb begin
        acc_next = beat_x;
        cnt_next = CNT_ONE;
        if (state_q == ACC) begin
            acc_next = acc_q ^ beat_x;
            cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end
    end

    // Frame FSM and accumulators.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (acc_en) begin
            acc_d   = acc_next;
            cnt_d   = cnt_next;
            state_d = in_last ? IDLE : ACC;
        end
    end

    // Beat parity and frame result.
    always_comb begin
        beat_par_d   = beat_par_q;
        beat_valid_d = acc_en;
        res_parity_d = res_parity_q;
        res_beats_d  = res_beats_q;
        res_valid_d  = res_valid_q;
        if (acc_en) begin
            beat_par_d = beat_x ^ INV;
        end
        // A last beat accepted in the same cycle as a result handshake wins:
        // the old result leaves and the new one is loaded with valid held.
        if (last_en) begin
            res_parity_d = acc_next ^ INV;
            res_beats_d  = cnt_next;
            res_valid_d  = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            beat_par_q   <= 1'b0;
            beat_valid_q <= 1'b0;
            res_parity_q <= 1'b0;
            res_beats_q  <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            beat_par_q   <= beat_par_d;
            beat_valid_q <= beat_valid_d;
            res_parity_q <= res_parity_d;
            res_beats_q  <= res_beats_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign beat_par   = beat_par_q;
    assign beat_valid = beat_valid_q;
    assign res_parity = res_parity_q;
    assign res_beats  = res_beats_q;
    assign res_valid  = res_valid_q;
    assign dbg_state  = state_q;

`ifdef PARITY_ERR_EN
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch;

    assign mismatch = (acc_next ^ INV) != in_exp;

    always_comb begin
        res_err_d = res_err_q;
        err_cnt_d = err_cnt_q;
        if (last_en) begin
            res_err_d = mismatch;
            if (mismatch && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            res_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            res_err_q <= res_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign res_err = res_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_accum.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_accum
//
// Three instances share one input stream:
//   u_m : WIDTH=3, INVERT=1, CNT_W=8 (main checks, table vectors)
//   u_x : WIDTH=3, INVERT=0, CNT_W=8 (XOR polarity)
//   u_s : WIDTH=3, INVERT=1, CNT_W=4 (count saturation)
// Inputs change after the falling edge; combinational in_ready is checked
// before the rising edge, registered outputs 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_parity_frame_accum;

    logic       clk;
    logic       areset;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       res_ready;

    logic       m_ir, m_bp, m_bv, m_rp, m_rv, m_st;
    logic [7:0] m_rb;
    logic       x_ir, x_bp, x_bv, x_rp, x_rv, x_st;
    logic [7:0] x_rb;
    logic       s_ir, s_bp, s_bv, s_rp, s_rv, s_st;
    logic [3:0] s_rb;
`ifdef PARITY_ERR_EN
    logic       in_exp;
    logic       m_err, x_err, s_err;
    logic [7:0] m_ecnt, x_ecnt;
    logic [3:0] s_ecnt;
`endif

    int n_checks;
    int n_err;

    parity_frame_accum #(.WIDTH(3), .INVERT(1), .CNT_W(8)) u_m (
        .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(m_ir), .beat_par(m_bp), .beat_valid(m_bv),
        .res_parity(m_rp), .res_beats(m_rb), .res_valid(m_rv),
        .res_ready(res_ready),
`ifdef PARITY_ERR_EN
        .in_exp(in_exp), .res_err(m_err), .err_cnt(m_ecnt),
`endif
        .dbg_state(m_st)
    );

    parity_frame_accum #(.WIDTH(3), .INVERT(0), .CNT_W(8)) u_x (
        .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(x_ir), .beat_par(x_bp), .beat_valid(x_bv),
        .res_parity(x_rp), .res_beats(x_rb), .res_valid(x_rv),
        .res_ready(res_ready),
`ifdef PARITY_ERR_EN
        .in_exp(in_exp), .res_err(x_err), .err_cnt(x_ecnt),
`endif
        .dbg_state(x_st)
    );

    parity_frame_accum #(.WIDTH(3), .INVERT(1), .CNT_W(4)) u_s (
        .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(s_ir), .beat_par(s_bp), .beat_valid(s_bv),
        .res_parity(s_rp), .res_beats(s_rb), .res_valid(s_rv),
        .res_ready(res_ready),
`ifdef PARITY_ERR_EN
        .in_exp(in_exp), .res_err(s_err), .err_cnt(s_ecnt),
`endif
        .dbg_state(s_st)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] d, input logic v, input logic l, input logic rr);
        @(negedge clk);
        in_data   = d;
        in_valid  = v;
        in_last   = l;
        res_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_data   = 3'b000;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        areset    = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        areset    = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] d;
        logic       v;
        logic       l;
        logic       rr;
        logic       ir;   // in_ready before the edge
        logic       bv;   // outputs after the edge
        logic       bp;
        logic       rv;
        logic       rp;
        logic [7:0] rb;
        logic       st;
    } vec_t;

    vec_t tbl[16];

    initial begin
        n_checks  = 0;
        n_err     = 0;
        areset    = 1'b1;
        in_data   = 3'b000;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
`ifdef PARITY_ERR_EN
        in_exp    = 1'b0;
`endif

        //          d       v     l     rr    ir    bv    bp    rv    rp    rb     st
        tbl[0]  = '{3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0}; // single-beat frame
        tbl[1]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0}; // result taken, data held
        tbl[2]  = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1}; // multi-beat first
        tbl[3]  = '{3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; // multi-beat last
        tbl[4]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; // stalled beat
        tbl[5]  = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; // stalled last
        tbl[6]  = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0}; // consume + load
        tbl[7]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0}; // held
        tbl[8]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0}; // consumed
        tbl[9]  = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0}; // back-to-back 1
        tbl[10] = '{3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0}; // back-to-back 2
        tbl[11] = '{3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0}; // last w/o valid
        tbl[12] = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1}; // 3-beat frame
        tbl[13] = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[14] = '{3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0};
        tbl[15] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0};

        // ---------------- reset state ----------------
        apply_reset();
        chk("rst in_ready",   32'(m_ir), 32'd1);
        chk("rst beat_valid", 32'(m_bv), 32'd0);
        chk("rst beat_par",   32'(m_bp), 32'd0);
        chk("rst res_valid",  32'(m_rv), 32'd0);
        chk("rst res_parity", 32'(m_rp), 32'd0);
        chk("rst res_beats",  32'(m_rb), 32'd0);
        chk("rst state",      32'(m_st), 32'd0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].rr);
            chk($sformatf("v%0d in_ready", i), 32'(m_ir), 32'(tbl[i].ir));
            tick();
            chk($sformatf("v%0d beat_valid", i), 32'(m_bv), 32'(tbl[i].bv));
            chk($sformatf("v%0d beat_par", i),   32'(m_bp), 32'(tbl[i].bp));
            chk($sformatf("v%0d res_valid", i),  32'(m_rv), 32'(tbl[i].rv));
            chk($sformatf("v%0d res_parity", i), 32'(m_rp), 32'(tbl[i].rp));
            chk($sformatf("v%0d res_beats", i),  32'(m_rb), 32'(tbl[i].rb));
            chk($sformatf("v%0d state", i),      32'(m_st), 32'(tbl[i].st));
        end

        // ---------------- XOR polarity ----------------
        apply_reset();
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        tick();
        chk("xor beat_par 1", 32'(x_bp), 32'd1);
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        chk("xor beat_par 2",   32'(x_bp), 32'd0);
        chk("xor res_valid",    32'(x_rv), 32'd1);
        chk("xor res_parity",   32'(x_rp), 32'd1);
        chk("xor res_beats",    32'(x_rb), 32'd2);
        chk("xnor res_parity",  32'(m_rp), 32'd0);

        // ---------------- saturation (20 beats of 000) ----------------
        apply_reset();
        for (int i = 0; i < 19; i++) begin
            drive(3'b000, 1'b1, 1'b0, 1'b1);
            tick();
        end
        chk("sat state mid", 32'(s_st), 32'd1);
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        chk("sat res_valid",    32'(s_rv), 32'd1);
        chk("sat res_beats",    32'(s_rb), 32'd15);
        chk("sat res_parity",   32'(s_rp), 32'd1);
        chk("wide res_beats",   32'(m_rb), 32'd20);

        // ---------------- asynchronous reset mid-frame ----------------
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        tick();
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        tick();
        chk("pre-rst state",      32'(m_st), 32'd1);
        chk("pre-rst beat_valid", 32'(m_bv), 32'd1);
        in_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        areset = 1'b1;
        #1;
        chk("arst beat_par",   32'(m_bp), 32'd0);
        chk("arst beat_valid", 32'(m_bv), 32'd0);
        chk("arst res_valid",  32'(m_rv), 32'd0);
        chk("arst res_parity", 32'(m_rp), 32'd0);
        chk("arst res_beats",  32'(m_rb), 32'd0);
        chk("arst in_ready",   32'(m_ir), 32'd1);
        chk("arst state",      32'(m_st), 32'd0);
        #1;
        areset = 1'b0;
        drive(3'b111, 1'b1, 1'b1, 1'b1);
        tick();
        chk("post-rst res_valid",  32'(m_rv), 32'd1);
        chk("post-rst res_parity", 32'(m_rp), 32'd0);
        chk("post-rst res_beats",  32'(m_rb), 32'd1);

`ifdef PARITY_ERR_EN
        // ---------------- expected-parity checking ----------------
        apply_reset();
        in_exp = 1'b0;
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        chk("err1 res_parity", 32'(m_rp),   32'd1);
        chk("err1 res_err",    32'(m_err),  32'd1);
        chk("err1 err_cnt",    32'(m_ecnt), 32'd1);
        drive(3'b001, 1'b1, 1'b1, 1'b1);
        tick();
        chk("err2 res_parity", 32'(m_rp),   32'd0);
        chk("err2 res_err",    32'(m_err),  32'd0);
        chk("err2 err_cnt",    32'(m_ecnt), 32'd1);
`endif

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
